// File: rtl/pfixed_to_pfloat.sv
// Two's-complement Q-format fixed point to IEEE-754 single precision.
// Begin/ACK handshake; normalisation shifts one bit per clock, mantissa truncated.
module pfixed_to_pfloat #(
   parameter int unsigned FRAC_BITS = 26
) (
   input  logic        CLK,
   input  logic        RST_FL,
   input  logic        RST_FSM_FL,
   input  logic        Begin_FSM_FL,
   input  logic [31:0] FIXED,
   output logic        ACK_FL,
   output logic [31:0] RESULT
);

   typedef enum logic [2:0] {
      IDLE,
      ABS,
      NORM,
      PACK,
      DONE
   } state_t;

   // Exponent bias folded with the binary-point position; k is subtracted at pack time.
   localparam logic [8:0] EXP_BASE = 9'(158 - FRAC_BITS);

   state_t      state, state_next;
   logic [31:0] operand;
   logic [31:0] mag;
   logic [4:0]  k;
   logic        sign;
   logic        zero;
   logic [7:0]  exp_field;

   assign exp_field = 8'(EXP_BASE - {4'd0, k});

   always_ff @(posedge CLK) begin
      if (RST_FL) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (RST_FSM_FL) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (Begin_FSM_FL) state_next = ABS;
            ABS:     state_next = (operand == '0) ? PACK : NORM;
            NORM:    if (mag[31]) state_next = PACK;
            PACK:    state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      ACK_FL = (state == DONE);
   end

   // An FSM reset freezes the datapath so RESULT keeps its last value.
   always_ff @(posedge CLK) begin
      if (RST_FL) begin
         operand <= '0;
         mag     <= '0;
         k       <= '0;
         sign    <= 1'b0;
         zero    <= 1'b0;
         RESULT  <= '0;
      end else if (!RST_FSM_FL) begin
         case (state)
            IDLE: begin
               if (Begin_FSM_FL) operand <= FIXED;
            end
            ABS: begin
               sign <= operand[31];
               mag  <= operand[31] ? (~operand + 32'd1) : operand;
               k    <= '0;
               zero <= (operand == '0);
            end
            NORM: begin
               if (!mag[31]) begin
                  mag <= mag << 1;
                  k   <= k + 5'd1;
               end
            end
            PACK: begin
               RESULT <= zero ? '0 : {sign, exp_field, mag[30:8]};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pfixed_to_pfloat.sv
// Directed bench for pfixed_to_pfloat (FRAC_BITS=26): results, latency, control.
module tb_pfixed_to_pfloat;

   logic        CLK = 1'b0;
   logic        RST_FL = 1'b1;
   logic        RST_FSM_FL = 1'b0;
   logic        Begin_FSM_FL = 1'b0;
   logic [31:0] FIXED = '0;
   logic        ACK_FL;
   logic [31:0] RESULT;

   int unsigned n_checks = 0;
   int unsigned n_fails  = 0;
   int unsigned edges;

   pfixed_to_pfloat #(.FRAC_BITS(26)) dut (
      .CLK(CLK),
      .RST_FL(RST_FL),
      .RST_FSM_FL(RST_FSM_FL),
      .Begin_FSM_FL(Begin_FSM_FL),
      .FIXED(FIXED),
      .ACK_FL(ACK_FL),
      .RESULT(RESULT)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   // Launch a conversion; returns at the negedge after e0 with edges=1.
   task automatic start(input logic [31:0] val);
      FIXED        = val;
      Begin_FSM_FL = 1'b1;
      tick();
      Begin_FSM_FL = 1'b0;
      FIXED        = 32'hDEAD_BEEF;
      edges        = 1;
   endtask

   // Waits for ACK (bounded). If pulse_at is nonzero, Begin is pulsed with a
   // different operand on that edge count to confirm it is ignored.
   task automatic wait_ack(input string tag, input int unsigned lat,
                           input logic [31:0] res, input int unsigned pulse_at);
      while (!ACK_FL && edges < 60) begin
         if (edges == pulse_at) begin
            Begin_FSM_FL = 1'b1;
            FIXED        = 32'h0400_0000;
         end
         tick();
         Begin_FSM_FL = 1'b0;
         edges++;
      end
      check({tag, "_lat"}, 32'(edges), 32'(lat));
      check({tag, "_res"}, RESULT, res);
      tick();
      check({tag, "_hold_ack"}, {31'd0, ACK_FL}, 32'd1);
      check({tag, "_hold_res"}, RESULT, res);
   endtask

   task automatic fsm_reset();
      RST_FSM_FL = 1'b1;
      tick();
      RST_FSM_FL = 1'b0;
   endtask

   initial begin
      @(negedge CLK);
      tick();
      tick();
      RST_FL = 1'b0;
      check("reset_ack", {31'd0, ACK_FL}, 32'd0);
      check("reset_res", RESULT, 32'h0000_0000);

      start(32'h0400_0000); wait_ack("pos_one", 9, 32'h3F80_0000, 0); fsm_reset();
      check("fsmrst_ack", {31'd0, ACK_FL}, 32'd0);
      check("fsmrst_res", RESULT, 32'h3F80_0000);
      // Back-to-back: capture on the edge right after DONE -> IDLE.
      start(32'hFC00_0000); wait_ack("neg_one", 9, 32'hBF80_0000, 0); fsm_reset();
      start(32'h0000_0000); wait_ack("zero", 3, 32'h0000_0000, 0); fsm_reset();
      start(32'h0000_0001); wait_ack("min", 35, 32'h3280_0000, 0); fsm_reset();
      start(32'h8000_0000); wait_ack("most_neg", 4, 32'hC200_0000, 0); fsm_reset();
      start(32'h7FFF_FFFF); wait_ack("trunc", 5, 32'h41FF_FFFF, 0); fsm_reset();
      start(32'h0000_0001); wait_ack("begin_ign", 35, 32'h3280_0000, 10); fsm_reset();

      // FSM reset mid-NORM abandons the conversion, RESULT untouched.
      start(32'h0000_0001);
      repeat (6) tick();
      fsm_reset();
      check("abort_ack", {31'd0, ACK_FL}, 32'd0);
      check("abort_res", RESULT, 32'h3280_0000);
      repeat (40) tick();
      check("abort_idle_ack", {31'd0, ACK_FL}, 32'd0);
      check("abort_idle_res", RESULT, 32'h3280_0000);

      // FSM reset beats Begin in IDLE: no capture.
      RST_FSM_FL = 1'b1; Begin_FSM_FL = 1'b1; FIXED = 32'h0400_0000;
      tick();
      RST_FSM_FL = 1'b0; Begin_FSM_FL = 1'b0;
      repeat (12) tick();
      check("prio_ack", {31'd0, ACK_FL}, 32'd0);
      check("prio_res", RESULT, 32'h3280_0000);

      start(32'hFC00_0000); wait_ack("after_abort", 9, 32'hBF80_0000, 0); fsm_reset();

      // System reset mid-conversion clears RESULT.
      start(32'h0000_0001);
      repeat (8) tick();
      RST_FL = 1'b1;
      tick();
      RST_FL = 1'b0;
      check("sysrst_ack", {31'd0, ACK_FL}, 32'd0);
      check("sysrst_res", RESULT, 32'h0000_0000);
      repeat (40) tick();
      check("sysrst_idle_ack", {31'd0, ACK_FL}, 32'd0);

      start(32'h0400_0000); wait_ack("after_sysrst", 9, 32'h3F80_0000, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/pfixed_to_pfloat.md
# pfixed_to_pfloat

Converts a 32-bit two's-complement fixed-point value back to IEEE-754 single precision. It sits directly downstream of the fixed-point datapath fed by the float-to-fixed converter, returning results to floating-point format. Handshake is Begin/ACK, the same as the converter:
- a start pulse launches one conversion;
- ACK is held until the FSM is reset by the controller.

Normalisation is iterative: one left shift per clock.

## Interface
Parameters:
- FRAC_BITS, default 26 — number of fractional bits in the fixed-point input (Q(31-FRAC_BITS).FRAC_BITS plus sign); legal range 0..31.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST_FL  input  1  system reset, synchronous, active-high.
- RST_FSM_FL  input  1  synchronous FSM reset; returns the controller to IDLE.
- Begin_FSM_FL  input  1  start; sampled only in IDLE.
- FIXED  input  32  two's-complement fixed-point operand.
- ACK_FL  output  1  conversion complete; RESULT is valid while high.
- RESULT  output  32  IEEE-754 single-precision result (registered).

## Operation
- States: IDLE, ABS, NORM, PACK, DONE.
- IDLE: if Begin_FSM_FL=1, register FIXED into the operand register and go to ABS. Otherwise stay.
- ABS:
  - sign ← operand[31];
  - mag ← sign ? (~operand+1) : operand, as 32-bit unsigned (0x80000000 maps to mag 0x80000000);
  - shift counter k ← 0.
  - If mag==0, set the zero flag and go to PACK; otherwise go to NORM.
- NORM: if mag[31]==1, go to PACK. Otherwise mag ← mag<<1, k ← k+1, stay. k is 5 bits and never exceeds 31.
- PACK:
  - zero flag set: RESULT ← 0x00000000 (+0.0).
  - otherwise: RESULT ← {sign, exp[7:0], mag[30:8]}, where exp = 127 + 31 − k − FRAC_BITS.
  - Go to DONE.
- Arithmetic rules:
  - exp is computed in at least 9 bits.
  - For FRAC_BITS 0..31, exp ranges over 96..158, so every result is a normal number: no denormal, overflow or infinity path.
  - Mantissa is truncated: mag[7:0] is discarded and there is no rounding.
- DONE: ACK_FL=1, RESULT held. Stays in DONE until RST_FSM_FL=1, then goes to IDLE.
- Begin_FSM_FL is ignored in every state except IDLE.
- RST_FSM_FL in any state:
  - next state is IDLE and ACK_FL drops;
  - RESULT keeps its last value;
  - an in-flight conversion is abandoned.
- Priority: RST_FL > RST_FSM_FL > Begin_FSM_FL. If RST_FSM_FL and Begin_FSM_FL are both high in IDLE, the block stays in IDLE and no capture occurs.

## Timing
- Reset values (RST_FL high at an edge): state IDLE, ACK_FL=0, RESULT=0x00000000, operand/mag/k/sign/zero flag all 0.
- RST_FL asserted mid-conversion aborts it on that edge.
- Edge e0 is the edge that samples Begin_FSM_FL=1 in IDLE. For non-zero input:
  - k = 31 − (index of the most significant 1 in mag);
  - ACK_FL is first high after edge e(k+3), i.e. k+4 edges including e0;
  - minimum is 4 (|FIXED| ≥ 2^31 − FRAC_BITS scale, mag[31]=1); maximum is 35 (mag=1).
- Zero input: ACK_FL is first high after e2 (3 edges).
- RESULT changes only on the PACK→DONE edge and on RST_FL. It is stable throughout DONE.
- FIXED may change freely after e0; it is captured once.
- A new conversion requires RST_FSM_FL (one or more cycles) and then Begin_FSM_FL. Minimum turnaround is: DONE → IDLE on one edge, then capture on the next edge.

## Test plan
All scenarios use FRAC_BITS=26.
- Positive unity: FIXED=0x04000000 → RESULT=0x3F800000; k=5, so ACK_FL is high after 9 edges.
- Negative unity: FIXED=0xFC000000 → RESULT=0xBF800000, same latency.
- Zero: FIXED=0x00000000 → RESULT=0x00000000, ACK after 3 edges.
- Extremes:
  - FIXED=0x00000001 → RESULT=0x32800000 (2^-26), ACK after 35 edges;
  - FIXED=0x80000000 → RESULT=0xC2000000 (−32.0), ACK after 4 edges.
- Truncation: FIXED=0x7FFFFFFF → RESULT=0x41FFFFFF (no round-up to 0x42000000).
- Control:
  - Begin_FSM_FL pulsed during NORM is ignored;
  - RST_FSM_FL mid-NORM returns to IDLE with ACK_FL=0 and RESULT unchanged;
  - RST_FL mid-conversion clears RESULT to 0 and ACK_FL to 0;
  - back-to-back conversions (0x04000000 then 0xFC000000) separated by a one-cycle RST_FSM_FL both yield correct results.
